// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [4:0]  REG_X0    = 5'd0;

    typedef enum logic {
        RUN,
        REDIR_WAIT
    } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and per-stage control outputs between the datapath
// (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_used_id;
    logic        rs2_used_id;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        redirect_ex;
    logic [31:0] redirect_pc_ex;
    logic        imem_ready;
    logic        dmem_busy;

    logic        pc_we;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;
    logic        fetch_timeout;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, ex_mem_read, ex_rd,
               redirect_ex, redirect_pc_ex, imem_ready, dmem_busy,
        input  pc_we, pc_redirect, redirect_pc, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, fetch_timeout
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, ex_mem_read, ex_rd,
               redirect_ex, redirect_pc_ex, imem_ready, dmem_busy,
        output pc_we, pc_redirect, redirect_pc, if_id_stall, if_id_flush,
               id_ex_stall, id_ex_flush, ex_mem_stall, fetch_timeout
    );

endinterface

// File: rtl/pipe_hazard_ctrl_watchdog.sv
// Fetch watchdog: counts consecutive imem-not-ready cycles, saturating at
// FETCH_TIMEOUT, and raises a sticky error flag when the limit is reached.
module hz_watchdog
    import pipe_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 64,
    parameter int TO_W          = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic imem_ready,
    output logic fetch_timeout
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(FETCH_TIMEOUT);

    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            flag_q, flag_d;

    // The flag is set on the same edge the counter reaches the limit.
    always_comb begin
        cnt_d  = cnt_q;
        if (imem_ready) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + TO_W'(1);
        end
        flag_d = flag_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign fetch_timeout = flag_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FETCH_TIMEOUT = 64,
    parameter int TO_W          = 10
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
    output logic [31:0]        perf_lu_cnt
`endif
);

    hz_state_t   state_q, state_d;
    logic [31:0] target_q, target_d;

    logic        lu;
    logic        lu_stall;
    logic        pc_we;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        if_id_stall;
    logic        if_id_flush;
    logic        id_ex_stall;
    logic        id_ex_flush;
    logic        ex_mem_stall;

    assign lu = hz.ex_mem_read && (hz.ex_rd != REG_X0) &&
                ((hz.rs1_used_id && (hz.rs1_id == hz.ex_rd)) ||
                 (hz.rs2_used_id && (hz.rs2_id == hz.ex_rd)));

    // While reset is asserted the pipeline is held with NOPs in IF/ID.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        lu_stall     = 1'b0;
        pc_we        = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = 32'h0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;

        if (!rst) begin
            if_id_flush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.dmem_busy) begin
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else if (hz.redirect_ex) begin
                        pc_redirect = 1'b1;
                        redirect_pc = hz.redirect_pc_ex;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (hz.imem_ready) begin
                            pc_we = 1'b1;
                        end else begin
                            target_d = hz.redirect_pc_ex;
                            state_d  = REDIR_WAIT;
                        end
                    end else if (lu) begin
                        lu_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (!hz.imem_ready) begin
                        if_id_flush = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                    end
                end
                REDIR_WAIT: begin
                    // EX holds only bubbles here, so a busy MEM stage just
                    // freezes the wait; a fresh redirect replaces the target.
                    pc_redirect = 1'b1;
                    redirect_pc = target_q;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (hz.dmem_busy) begin
                        ex_mem_stall = 1'b1;
                    end else begin
                        if (hz.redirect_ex) begin
                            redirect_pc = hz.redirect_pc_ex;
                            target_d    = hz.redirect_pc_ex;
                        end
                        if (hz.imem_ready) begin
                            pc_we   = 1'b1;
                            state_d = RUN;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    hz_watchdog #(
        .FETCH_TIMEOUT (FETCH_TIMEOUT),
        .TO_W          (TO_W)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (hz.imem_ready),
        .fetch_timeout (hz.fetch_timeout)
    );

    assign hz.pc_we        = pc_we;
    assign hz.pc_redirect  = pc_redirect;
    assign hz.redirect_pc  = redirect_pc;
    assign hz.if_id_stall  = if_id_stall;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_stall  = id_ex_stall;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.ex_mem_stall = ex_mem_stall;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] lu_cnt_q, lu_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ~pc_we};
        flush_cnt_d = flush_cnt_q + {31'd0, id_ex_flush};
        lu_cnt_d    = lu_cnt_q + {31'd0, lu_stall};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
            lu_cnt_q    <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_lu_cnt    = lu_cnt_q;
`else
    logic unused_lu_stall;
    assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all checked against a behavioural model of the rules.
module tb_pipe_hazard_ctrl;

    localparam int FT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_next = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;
`endif

    pipe_hazard_ctrl #(
        .FETCH_TIMEOUT (FT),
        .TO_W          (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .hz             (hz.slave)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_lu_cnt    (perf_lu_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether a redirect is still waiting for fetch, its target,
    // the run of not-ready fetch cycles, the sticky error, and event tallies.
    bit          m_wait;
    logic [31:0] m_target;
    int          m_nrdy;
    bit          m_err;
    logic [31:0] m_stall_n, m_flush_n, m_lu_n;

    bit          e_pc_we, e_pc_redirect, e_if_stall, e_if_flush;
    bit          e_id_stall, e_id_flush, e_exm_stall, e_hold;
    logic [31:0] e_rpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_wait    = 0;
        m_target  = 32'h0;
        m_nrdy    = 0;
        m_err     = 0;
        m_stall_n = 32'h0;
        m_flush_n = 32'h0;
        m_lu_n    = 32'h0;
    endtask

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic mr,
                                 input logic [4:0] rd, input logic redir,
                                 input logic [31:0] tgt, input logic imem,
                                 input logic busy);
        @(negedge clk);
        rst               = rst_next;
        hz.rs1_id         = rs1;
        hz.rs2_id         = rs2;
        hz.rs1_used_id    = u1;
        hz.rs2_used_id    = u2;
        hz.ex_mem_read    = mr;
        hz.ex_rd          = rd;
        hz.redirect_ex    = redir;
        hz.redirect_pc_ex = tgt;
        hz.imem_ready     = imem;
        hz.dmem_busy      = busy;
    endtask

    task automatic computeExpected();
        bit load_use;
        load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                   ((hz.rs1_used_id && hz.rs1_id == hz.ex_rd) ||
                    (hz.rs2_used_id && hz.rs2_id == hz.ex_rd));
        e_pc_we = 0; e_pc_redirect = 0; e_if_stall = 0; e_if_flush = 0;
        e_id_stall = 0; e_id_flush = 0; e_exm_stall = 0; e_hold = 0;
        e_rpc = 32'h0;
        if (!rst) begin
            e_if_flush = 1;
        end else if (m_wait) begin
            e_pc_redirect = 1;
            e_if_flush    = 1;
            e_id_flush    = 1;
            e_exm_stall   = hz.dmem_busy;
            e_rpc         = (!hz.dmem_busy && hz.redirect_ex) ? hz.redirect_pc_ex : m_target;
            e_pc_we       = !hz.dmem_busy && hz.imem_ready;
        end else if (hz.dmem_busy) begin
            e_if_stall = 1; e_id_stall = 1; e_exm_stall = 1;
        end else if (hz.redirect_ex) begin
            e_pc_redirect = 1;
            e_rpc         = hz.redirect_pc_ex;
            e_if_flush    = 1;
            e_id_flush    = 1;
            e_pc_we       = hz.imem_ready;
        end else if (load_use) begin
            e_hold = 1; e_if_stall = 1; e_id_flush = 1;
        end else begin
            e_pc_we    = hz.imem_ready;
            e_if_flush = !hz.imem_ready;
        end
    endtask

    task automatic checkOutput();
        #1;
        computeExpected();
        chk("pc_we",         hz.pc_we,         e_pc_we);
        chk("pc_redirect",   hz.pc_redirect,   e_pc_redirect);
        chk("redirect_pc",   hz.redirect_pc,   e_rpc);
        chk("if_id_stall",   hz.if_id_stall,   e_if_stall);
        chk("if_id_flush",   hz.if_id_flush,   e_if_flush);
        chk("id_ex_stall",   hz.id_ex_stall,   e_id_stall);
        chk("id_ex_flush",   hz.id_ex_flush,   e_id_flush);
        chk("ex_mem_stall",  hz.ex_mem_stall,  e_exm_stall);
        chk("fetch_timeout", hz.fetch_timeout, m_err);
        chk("inv_if_id",     hz.if_id_stall & hz.if_id_flush, 1'b0);
        chk("inv_id_ex",     hz.id_ex_stall & hz.id_ex_flush, 1'b0);
        chk("inv_redir",     hz.pc_redirect & ~hz.if_id_flush, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall",    perf_stall_cnt,   m_stall_n);
        chk("perf_flush",    perf_flush_cnt,   m_flush_n);
        chk("perf_lu",       perf_lu_cnt,      m_lu_n);
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            modelReset();
        end else begin
            if (m_wait) begin
                if (!hz.dmem_busy) begin
                    if (hz.redirect_ex) m_target = hz.redirect_pc_ex;
                    if (hz.imem_ready) m_wait = 0;
                end
            end else if (!hz.dmem_busy && hz.redirect_ex && !hz.imem_ready) begin
                m_wait   = 1;
                m_target = hz.redirect_pc_ex;
            end
            m_nrdy = hz.imem_ready ? 0 : ((m_nrdy < FT) ? m_nrdy + 1 : FT);
            if (m_nrdy >= FT) m_err = 1;
            m_stall_n = m_stall_n + (e_pc_we ? 32'd0 : 32'd1);
            m_flush_n = m_flush_n + (e_id_flush ? 32'd1 : 32'd0);
            m_lu_n    = m_lu_n + (e_hold ? 32'd1 : 32'd0);
        end
    endtask

    task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic mr,
                         input logic [4:0] rd, input logic redir,
                         input logic [31:0] tgt, input logic imem, input logic busy);
        applyStimulus(rs1, rs2, u1, u2, mr, rd, redir, tgt, imem, busy);
        checkOutput();
        advance();
    endtask

    task automatic idle(input logic imem);
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, imem, 1'b0);
    endtask

    initial begin
        modelReset();
        rst = 1'b0;
        rst_next = 1'b0;
        hz.rs1_id = '0; hz.rs2_id = '0; hz.rs1_used_id = 0; hz.rs2_used_id = 0;
        hz.ex_mem_read = 0; hz.ex_rd = '0; hz.redirect_ex = 0;
        hz.redirect_pc_ex = '0; hz.imem_ready = 1; hz.dmem_busy = 0;

        // Held in reset: NOPs into IF/ID, PC frozen.
        idle(1'b1);
        chk("reset_pc_we", hz.pc_we, 1'b0);
        chk("reset_if_id_flush", hz.if_id_flush, 1'b1);
        idle(1'b1);
        rst_next = 1'b1;
        idle(1'b1);
        chk("release_pc_we", hz.pc_we, 1'b1);

        // Load-use on rs1 and rs2, then x0 destination which must not stall.
        cycle(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("lu_if_id_stall", hz.if_id_stall, 1'b1);
        idle(1'b1);
        chk("lu_cleared_pc_we", hz.pc_we, 1'b1);
        cycle(5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("lu_x0_pc_we", hz.pc_we, 1'b1);
        cycle(5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 32'h0, 1'b1, 1'b0);

        // Redirect with fetch ready.
        cycle(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        chk("redir_pc", hz.redirect_pc, 32'h0000_0100);
        idle(1'b1);

        // Redirect during fetch wait, replaced by a younger one.
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        idle(1'b0);
        chk("wait_redirect_pc", hz.redirect_pc, 32'h0000_0300);
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        chk("wait_exit_pc_we", hz.pc_we, 1'b1);
        idle(1'b1);

        // MEM busy freezes everything, even a redirect and a load-use.
        for (int i = 0; i < 4; i++) begin
            cycle(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
            chk("busy_ex_mem_stall", hz.ex_mem_stall, 1'b1);
        end
        cycle(5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1, 32'h0000_0400, 1'b1, 1'b0);
        chk("busy_end_redirect", hz.pc_redirect, 1'b1);
        idle(1'b1);

        // Watchdog: one short of the limit, then exactly the limit.
        for (int i = 0; i < FT - 1; i++) idle(1'b0);
        idle(1'b1);
        chk("wd_short_run", hz.fetch_timeout, 1'b0);
        for (int i = 0; i < FT; i++) idle(1'b0);
        idle(1'b1);
        chk("wd_limit_run", hz.fetch_timeout, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while waiting on a redirect.
        cycle(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        rst_next = 1'b0;
        modelReset();
        checkOutput();
        chk("async_rst_pc_redirect", hz.pc_redirect, 1'b0);
        chk("async_rst_timeout", hz.fetch_timeout, 1'b0);
        advance();
        rst_next = 1'b1;
        idle(1'b1);
        chk("post_rst_run_pc_we", hz.pc_we, 1'b1);

        // Random traffic with narrow register ranges to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
